// File: rtl/sensor_regfile_if.sv
// rtl/sensor_regfile_if.sv - bus bundle for the double-buffered sensor register file
interface sensor_regfile_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              commit;
  logic              test_mode;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_err;
  logic              stale;
  logic [7:0]        frame_cnt;

  // Producer of writes/commits/reads (host side)
  modport master (
    output wr_en, wr_addr, wr_data, commit, test_mode, rd_en, rd_addr,
    input  rd_data, rd_valid, wr_err, stale, frame_cnt
  );

  // The register file itself
  modport slave (
    input  wr_en, wr_addr, wr_data, commit, test_mode, rd_en, rd_addr,
    output rd_data, rd_valid, wr_err, stale, frame_cnt
  );
endinterface

// File: rtl/sensor_regfile.sv
// rtl/sensor_regfile.sv - shadow/active sensor register banks with commit, test pattern and staleness
module sensor_regfile #(
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 4,
  parameter int ADDR_W    = 4,
  parameter int TICK_DIV  = 1024,
  parameter int STALE_CYC = 2**20
) (
  input  logic            clk,
  input  logic            rst,
  sensor_regfile_if.slave bus
);
  localparam int DIV_W   = $clog2(TICK_DIV);
  localparam int STALE_W = $clog2(STALE_CYC + 1);

  logic [DATA_W-1:0]  shadow_q [NUM_REGS];
  logic [DATA_W-1:0]  shadow_d [NUM_REGS];
  logic [DATA_W-1:0]  active_q [NUM_REGS];
  logic [DATA_W-1:0]  active_d [NUM_REGS];
  logic [DATA_W-1:0]  pat_q, pat_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [STALE_W-1:0] stale_cnt_q, stale_cnt_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               wr_err_q, wr_err_d;
  logic               tick;
  logic               commit_ok;

  // Commits only reach the active bank in normal mode; the pattern generator owns it otherwise
  assign commit_ok = bus.commit & ~bus.test_mode;

  // Shadow write; an address matching no register flags an error instead
  always_comb begin
    shadow_d = shadow_q;
    wr_err_d = 1'b0;
    if (bus.wr_en) begin
      wr_err_d = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus.wr_addr == ADDR_W'(i)) begin
          shadow_d[i] = bus.wr_data;
          wr_err_d    = 1'b0;
        end
      end
    end
  end

  // Test-pattern divider; held at zero whenever test mode is off so entry is deterministic
  always_comb begin
    div_d = '0;
    pat_d = '0;
    tick  = 1'b0;
    if (bus.test_mode) begin
      if (div_q == DIV_W'(TICK_DIV - 1)) begin
        tick  = 1'b1;
        pat_d = pat_q + DATA_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
        pat_d = pat_q;
      end
    end
  end

  // Active bank update; copying shadow_d forwards a same-cycle write into the snapshot
  always_comb begin
    active_d = active_q;
    if (tick) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        active_d[i] = pat_q + DATA_W'(i);
      end
    end else if (commit_ok) begin
      active_d = shadow_d;
    end
  end

  // Frame counter and saturating staleness counter, both driven by active-bank updates
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    stale_cnt_d = stale_cnt_q;
    if (tick || commit_ok) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      stale_cnt_d = '0;
    end else if (stale_cnt_q != STALE_W'(STALE_CYC)) begin
      stale_cnt_d = stale_cnt_q + STALE_W'(1);
    end
  end

  // Read port samples the pre-update active bank; unmapped addresses read as zero
  always_comb begin
    rd_valid_d = bus.rd_en;
    rd_data_d  = rd_data_q;
    if (bus.rd_en) begin
      rd_data_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus.rd_addr == ADDR_W'(i)) begin
          rd_data_d = active_q[i];
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pat_q       <= '0;
      div_q       <= '0;
      frame_cnt_q <= '0;
      stale_cnt_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pat_q       <= pat_d;
      div_q       <= div_d;
      frame_cnt_q <= frame_cnt_d;
      stale_cnt_q <= stale_cnt_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.wr_err    = wr_err_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.stale     = (stale_cnt_q == STALE_W'(STALE_CYC));
endmodule
